// File: rtl/floo_wormhole_credit_arbiter.sv
// ----------------------------------------------------------------------------
// floo_wormhole_credit_arbiter
//
// Round-robin arbiter for several wormhole-switched inputs sharing one output
// link.  A packet that wins with a non-tail flit keeps the output (LOCKED)
// until its tail flit passes.  The downstream buffer is tracked with a credit
// counter.  No flit is forwarded while the counter is zero.
//
// Ports:
//   clk_i         clock; all state changes on its rising edge
//   rst_i         asynchronous active-high reset
//   valid_i       per-input flit valid            [NumInputs]
//   last_i        per-input flit is packet tail   [NumInputs]
//   ready_o       per-input flit accepted         [NumInputs]
//   valid_o       flit forwarded to output link this cycle
//   sel_id_o      index of forwarded input (0 when idle) [IdW]
//   credit_i      one-cycle pulse returning one downstream credit
//   locked_o      a packet currently holds the output
//   credits_o     current credit count            [CntW]
//   credit_err_o  sticky credit-overflow flag
// ----------------------------------------------------------------------------
module floo_wormhole_credit_arbiter #(
    parameter  int unsigned NumInputs  = 4,
    parameter  int unsigned NumCredits = 4,
    localparam int unsigned IdW        = (NumInputs > 1) ? $clog2(NumInputs) : 1,
    localparam int unsigned CntW       = $clog2(NumCredits + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NumInputs-1:0] valid_i,
    input  logic [NumInputs-1:0] last_i,
    output logic [NumInputs-1:0] ready_o,
    output logic                 valid_o,
    output logic [IdW-1:0]       sel_id_o,
    input  logic                 credit_i,
    output logic                 locked_o,
    output logic [CntW-1:0]      credits_o,
    output logic                 credit_err_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e          state_q,   state_d;
    logic [IdW-1:0]  lock_id_q, lock_id_d;
    logic [IdW-1:0]  rr_ptr_q,  rr_ptr_d;
    logic [CntW-1:0] count_q,   count_d;
    logic            err_q,     err_d;

    logic            found;
    logic            xfer;
    logic            cred_ok;
    logic [IdW-1:0]  grant_id;
    logic [IdW-1:0]  grant_next;
    int unsigned     scan;

    assign cred_ok = (count_q != '0);

    // Winner selection.  In IDLE, scan from rr_ptr upward with wrap; in
    // LOCKED only the owning input is considered.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        scan     = 0;
        if (state_q == IDLE) begin
            for (int unsigned i = 0; i < NumInputs; i++) begin
                scan = 32'(rr_ptr_q) + i;
                if (scan >= NumInputs) begin
                    scan = scan - NumInputs;
                end
                if (!found && valid_i[scan[IdW-1:0]]) begin
                    found    = 1'b1;
                    grant_id = scan[IdW-1:0];
                end
            end
        end else begin
            grant_id = lock_id_q;
            found    = valid_i[lock_id_q];
        end
    end

    // Reset also gates the combinational outputs so the link stays quiet
    // while rst_i is held, even though count_q already reads NumCredits.
    assign xfer = found && cred_ok && !rst_i;

    always_comb begin
        ready_o  = '0;
        valid_o  = 1'b0;
        sel_id_o = '0;
        if (xfer) begin
            ready_o  = NumInputs'(1) << grant_id;
            valid_o  = 1'b1;
            sel_id_o = grant_id;
        end
    end

    always_comb begin
        if (32'(grant_id) + 1 >= NumInputs) begin
            grant_next = '0;
        end else begin
            grant_next = grant_id + IdW'(1);
        end
    end

    // Next-state: tail flit releases the output and advances the pointer;
    // a non-tail flit won in IDLE takes the lock.
    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        rr_ptr_d  = rr_ptr_q;
        if (xfer) begin
            if (last_i[grant_id]) begin
                state_d  = IDLE;
                rr_ptr_d = grant_next;
            end else if (state_q == IDLE) begin
                state_d   = LOCKED;
                lock_id_d = grant_id;
            end
        end
    end

    // Credit counter: a send and a return in the same cycle cancel out.
    // A return at full count is an overflow: count held, error latched.
    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        if (xfer && !credit_i) begin
            count_d = count_q - CntW'(1);
        end else if (!xfer && credit_i) begin
            if (count_q == CntW'(NumCredits)) begin
                err_d = 1'b1;
            end else begin
                count_d = count_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            lock_id_q <= '0;
            rr_ptr_q  <= '0;
            count_q   <= CntW'(NumCredits);
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            rr_ptr_q  <= rr_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    assign locked_o     = (state_q == LOCKED);
    assign credits_o    = count_q;
    assign credit_err_o = err_q;

endmodule

// File: tb/tb_floo_wormhole_credit_arbiter.sv
// ----------------------------------------------------------------------------
// tb_floo_wormhole_credit_arbiter
//
// Directed scenarios followed by a randomized phase, all compared cycle by
// cycle against a behavioural model of the arbitration and credit rules.
// ----------------------------------------------------------------------------
module tb_floo_wormhole_credit_arbiter;

    localparam int N  = 4;
    localparam int NC = 4;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [N-1:0] valid_i;
    logic [N-1:0] last_i;
    logic [N-1:0] ready_o;
    logic         valid_o;
    logic [1:0]   sel_id_o;
    logic         credit_i;
    logic         locked_o;
    logic [2:0]   credits_o;
    logic         credit_err_o;

    floo_wormhole_credit_arbiter #(
        .NumInputs (N),
        .NumCredits(NC)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .last_i      (last_i),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .sel_id_o    (sel_id_o),
        .credit_i    (credit_i),
        .locked_o    (locked_o),
        .credits_o   (credits_o),
        .credit_err_o(credit_err_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    bit m_locked;
    int m_lock;
    int m_rr;
    int m_cred;
    bit m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
    task automatic step(input logic r, input logic [N-1:0] v, input logic [N-1:0] l,
                        input logic c);
        int  w;
        bit  xfer;
        rst_i    = r;
        valid_i  = v;
        last_i   = l;
        credit_i = c;
        #2;
        if (r) begin
            m_locked = 0;
            m_lock   = 0;
            m_rr     = 0;
            m_cred   = NC;
            m_err    = 0;
        end
        w = -1;
        if (!r) begin
            if (m_locked) begin
                if (v[m_lock]) w = m_lock;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && v[(m_rr + k) % N]) w = (m_rr + k) % N;
                end
            end
        end
        xfer = (w >= 0) && (m_cred > 0);
        vectors++;
        chk("ready",   32'(ready_o),      xfer ? (32'd1 << w) : 32'd0);
        chk("valid",   32'(valid_o),      32'(xfer));
        chk("sel_id",  32'(sel_id_o),     xfer ? 32'(w) : 32'd0);
        chk("locked",  32'(locked_o),     32'(m_locked));
        chk("credits", 32'(credits_o),    32'(m_cred));
        chk("err",     32'(credit_err_o), 32'(m_err));
        if (!r) begin
            if (xfer) begin
                if (l[w]) begin
                    m_locked = 0;
                    m_rr     = (w + 1) % N;
                end else if (!m_locked) begin
                    m_locked = 1;
                    m_lock   = w;
                end
            end
            if (xfer && !c) m_cred--;
            else if (!xfer && c) begin
                if (m_cred == NC) m_err = 1;
                else m_cred++;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1; valid_i = '0; last_i = '0; credit_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Reset with traffic present: outputs must stay quiet
        step(1, 4'b1111, 4'b1111, 1);
        step(1, 4'b1111, 4'b0000, 0);

        // Round-robin of single-flit packets, credits returned after first
        step(0, 4'b1111, 4'b1111, 0);
        step(0, 4'b1111, 4'b1111, 1);
        step(0, 4'b1111, 4'b1111, 1);
        step(0, 4'b1111, 4'b1111, 1);

        // 3-flit packet on input 1 holds the output against input 2
        step(1, 4'b0000, 4'b0000, 0);
        step(0, 4'b0110, 4'b0000, 1);
        step(0, 4'b0110, 4'b0100, 1);
        step(0, 4'b0110, 4'b0110, 1);
        step(0, 4'b0100, 4'b0100, 1);
        step(0, 4'b0000, 4'b0000, 0);

        // Credit exhaustion, then one returned credit admits one flit
        step(1, 4'b0000, 4'b0000, 0);
        for (int i = 0; i < 6; i++) step(0, 4'b0001, 4'b0001, 0);
        step(0, 4'b0001, 4'b0001, 1);
        step(0, 4'b0001, 4'b0001, 0);
        step(0, 4'b0001, 4'b0001, 0);

        // Credit overflow with no traffic; error is sticky
        step(1, 4'b0000, 4'b0000, 0);
        step(0, 4'b0000, 4'b0000, 1);
        step(0, 4'b0000, 4'b0000, 1);
        for (int i = 0; i < 3; i++) step(0, 4'b0000, 4'b0000, 0);
        step(0, 4'b0001, 4'b0001, 0);
        step(0, 4'b0000, 4'b0000, 0);

        // Reset mid-packet while locked on input 3 with one credit left
        step(1, 4'b0000, 4'b0000, 0);
        step(0, 4'b1000, 4'b0000, 0);
        step(0, 4'b1000, 4'b0000, 0);
        step(0, 4'b1000, 4'b0000, 0);
        step(1, 4'b1000, 4'b0000, 0);
        step(0, 4'b1001, 4'b1001, 0);
        step(0, 4'b1001, 4'b1001, 0);

        // Valid bubble inside a locked packet; other inputs toggle freely
        step(1, 4'b0000, 4'b0000, 0);
        step(0, 4'b0010, 4'b0000, 0);
        step(0, 4'b1101, 4'b1101, 0);
        step(0, 4'b1011, 4'b1001, 0);
        step(0, 4'b1111, 4'b0010, 0);
        step(0, 4'b1111, 4'b1111, 0);

        // Randomized traffic
        step(1, 4'b0000, 4'b0000, 0);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0),
                 4'($urandom),
                 4'($urandom) & 4'($urandom),
                 ($urandom_range(0, 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/floo_wormhole_credit_arbiter.md
FLOO_WORMHOLE_CREDIT_ARBITER -- requirements
Module: floo_wormhole_credit_arbiter

Interface
REQ-001 SHALL have parameter NumInputs, default 4, number of input ports sharing one output link (range 1..16).
REQ-002 SHALL have parameter NumCredits, default 4, downstream buffer depth in flits (range 1..255).
REQ-003 SHALL derive IdW = (NumInputs>1 ? clog2(NumInputs) : 1) and CntW = clog2(NumCredits+1).
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have port valid_i, input, NumInputs, per-input flit valid.
REQ-007 SHALL have port last_i, input, NumInputs, per-input flit is tail of packet.
REQ-008 SHALL have port ready_o, output, NumInputs, per-input flit accepted this cycle.
REQ-009 SHALL have port valid_o, output, 1, flit forwarded to output link this cycle.
REQ-010 SHALL have port sel_id_o, output, IdW, index of the forwarded input; datapath mux select.
REQ-011 SHALL have port credit_i, input, 1, one-cycle pulse returning one downstream credit.
REQ-012 SHALL have port locked_o, output, 1, high while a packet holds the output.
REQ-013 SHALL have port credits_o, output, CntW, current credit count.
REQ-014 SHALL have port credit_err_o, output, 1, sticky credit overflow flag.

Function
REQ-015 SHALL keep state: fsm {IDLE, LOCKED}, lock_id (IdW), rr_ptr (IdW), credit count (CntW), err flag.
REQ-016 SHALL define cred_ok = (count != 0); no flit is accepted when count == 0.
REQ-017 IDLE: candidates = valid_i; winner w = first set index scanning rr_ptr, rr_ptr+1, ... wrapping at NumInputs.
REQ-018 IDLE with any candidate and cred_ok: ready_o = onehot(w), valid_o = 1, sel_id_o = w, same cycle (zero latency).
REQ-019 IDLE transfer with last_i[w]=1: stay IDLE, rr_ptr <= (w+1) mod NumInputs.
REQ-020 IDLE transfer with last_i[w]=0: next state LOCKED, lock_id <= w; rr_ptr unchanged.
REQ-021 LOCKED: only lock_id eligible; ready_o = onehot(lock_id) iff valid_i[lock_id] and cred_ok; other inputs get ready_o = 0 regardless of valid_i.
REQ-022 LOCKED transfer with last_i[lock_id]=1: next state IDLE, rr_ptr <= (lock_id+1) mod NumInputs.
REQ-023 LOCKED with no transfer (bubble or no credit): remain LOCKED, no state change except credits.
REQ-024 IDLE with no candidate or count==0: ready_o = 0, valid_o = 0, rr_ptr unchanged.
REQ-025 sel_id_o SHALL be 0 when valid_o = 0; valid_o SHALL equal |ready_o.
REQ-026 Credit update: count_next = count - valid_o + credit_i; simultaneous send and return leaves count unchanged.
REQ-027 credit_i with count == NumCredits and valid_o = 0: count held at NumCredits, credit_err_o set to 1 and held until reset.
REQ-028 locked_o SHALL be 1 exactly when fsm == LOCKED (registered); credits_o SHALL be the registered count.
REQ-029 NumInputs == 1: arbitration degenerates to pass-through gated by credits; rr_ptr, sel_id_o constant 0.
REQ-030 Single-flit packet (valid & last in IDLE) SHALL never enter LOCKED.
REQ-031 Changes of valid_i/last_i on non-selected inputs SHALL not affect outputs while LOCKED.

Reset
REQ-032 rst_i high SHALL immediately force fsm=IDLE, lock_id=0, rr_ptr=0, count=NumCredits, err=0.
REQ-033 During reset: ready_o=0, valid_o=0, sel_id_o=0, locked_o=0, credits_o=NumCredits, credit_err_o=0.
REQ-034 Reset asserted mid-packet SHALL abandon the lock; after release arbitration restarts from input 0.

Verification
REQ-035 N=4, C=4; valid_i=4'b1111, last_i=4'b1111 for 4 cycles, credit_i=1 every cycle after first -> sel_id_o 0,1,2,3; credits_o 4,3,3,3.
REQ-036 valid_i=4'b0110, 3-flit packet on input 1 (last on 3rd), input 2 single flit -> sel 1,1,1 with locked_o=1 cycles 2-3, then sel 2; input 2 ready_o=0 during lock.
REQ-037 No credit_i, single input streaming 6 flits -> 4 accepted, credits_o reaches 0, ready_o=0 thereafter; one credit_i pulse -> exactly one more flit accepted next cycle.
REQ-038 Count=4, no traffic, credit_i=1 -> credits_o stays 4, credit_err_o=1 and remains 1 until rst_i.
REQ-039 Assert rst_i while LOCKED on input 3 with credits_o=1 -> same-cycle outputs zero, locked_o=0, credits_o=4; after release, valid_i=4'b1001 -> input 0 granted first.
REQ-040 Locked packet with valid bubble (valid_i[lock_id]=0 one cycle) while other inputs valid -> valid_o=0 that cycle, lock kept, packet resumes on same input.
